universal_shift_reg: RTL and testbench
======================================

Name: universal_shift_reg

Overview:
- Parametrised universal shift register. It is the next generation of the team's 4-bit bidirectional shift register.
- Supports WIDTH-bit shift left/right, rotate left/right, arithmetic shift right and parallel load.
- Runs multi-step commands: one command shifts `cnt` positions, one bit per enabled cycle, using a start/busy/done handshake.
- Serves as a serialiser/deserialiser and bit-manipulation engine in datapath and serial-link blocks.

Parameters:
- WIDTH, 8: register width in bits, minimum 2.
- CNT_W, 4: width of the shift-count field. The maximum count is 2^CNT_W-1 and may exceed WIDTH.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: reset, synchronous, active-high.
- en, in, 1: global enable. Low stalls all state changes.
- start, in, 1: command request, sampled only when en=1 and idle.
- op, in, 3: operation code, captured with start.
- cnt, in, CNT_W: number of single-bit steps, captured with start.
- d_load, in, WIDTH: parallel load data for op LOAD.
- sin_msb, in, 1: serial input shifted into bit WIDTH-1 on SHR.
- sin_lsb, in, 1: serial input shifted into bit 0 on SHL.
- q, out, WIDTH: register contents.
- sout_msb, out, 1: equals q[WIDTH-1], combinational from q.
- sout_lsb, out, 1: equals q[0], combinational from q.
- busy, out, 1: multi-step command in progress.
- done, out, 1: single-cycle completion pulse.

Behaviour:
- Reset: rst has priority over everything. q=0, busy=0, done=0, FSM to IDLE, remaining count=0.
- Reset mid-command aborts the command with no done pulse.
- Op encoding:
  - 0 SHR: q <= {sin_msb, q[W-1:1]}
  - 1 SHL: q <= {q[W-2:0], sin_lsb}
  - 2 ROR: q <= {q[0], q[W-1:1]}
  - 3 ROL: q <= {q[W-2:0], q[W-1]}
  - 4 ASR: q <= {q[W-1], q[W-1:1]}
  - 5 LOAD: q <= d_load
  - 6, 7: reserved, treated as a no-op.
- FSM states: IDLE, RUN.
- IDLE, with en=1 and start=1:
  - If op=LOAD: q <= d_load at this edge. Stay IDLE. done=1 for the next cycle. busy stays 0. cnt is ignored.
  - If op is reserved, or cnt=0: q unchanged, stay IDLE, done=1 for the next cycle.
  - Otherwise: latch op and cnt into op_r and rem. Go to RUN; busy=1 from the next cycle.
  - No shift occurs at the capture edge.
- RUN, with en=1: apply one step of op_r at each edge and decrement rem.
  - Serial inputs are sampled live at each step edge.
  - On the edge where rem goes 1->0: go to IDLE, busy <= 0, done <= 1 for exactly one cycle.
- Latency: start at edge T with cnt=N>0 gives steps at edges T+1..T+N when there are no stalls. busy is high for N cycles, then done is high for 1 cycle.
- en=0: q, rem, state and busy all hold.
  - done still clears after one cycle, so it never stretches.
  - start is ignored.
- start while busy: ignored, with no queuing.
- start in the cycle where done is high: accepted normally, giving back-to-back commands.
- cnt > WIDTH:
  - SHR/SHL/ASR keep filling.
  - ROR/ROL wrap modulo WIDTH naturally, one step at a time.
- d_load, op and cnt are don't-care except at the capture edge. The exception is d_load, which is used only at the LOAD edge.

Decomposition:
- Package universal_shift_pkg contains:
  - op codes: OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_ASR, OP_LOAD
  - state enum: ST_IDLE, ST_RUN
- Sub-module universal_shift_step is purely combinational. Given q, op, sin_msb and sin_lsb, it returns the next q for one step.
- Top module contains the FSM, the count register and the q register.

Test Plan:
- Assert rst for 2 cycles with random inputs -> q=0x00, busy=0, done=0. Release -> all stay 0 with no start.
- LOAD d_load=0xA5, then SHL cnt=3 with sin_lsb=1 -> q=0xA5 one cycle after the LOAD edge. busy high for 3 cycles, final q=0x2F, done high for exactly 1 cycle.
- LOAD 0x81, ROR cnt=1 -> q=0xC0. LOAD 0x81, ROL cnt=9 -> q=0x03, busy high 9 cycles.
- LOAD 0x90, ASR cnt=2 -> q=0xE4. Then start with cnt=0 -> q stays 0xE4, done pulses next cycle, busy never asserts.
- LOAD 0xF0, SHR cnt=4 with sin_msb=0, drop en for 2 cycles after step 2, and pulse start with op=LOAD during busy -> busy high 6 cycles, q=0x0F, LOAD ignored, single done.
- SHL cnt=8 running, assert rst after step 3 -> next cycle q=0x00, busy=0, no done pulse. A subsequent LOAD 0x3C works normally.

Source files
------------

// File: rtl/universal_shift_pkg.sv
// rtl/universal_shift_pkg.sv - op codes, FSM states and helpers for universal_shift_reg
package universal_shift_pkg;

  localparam logic [2:0] OP_SHR  = 3'd0;
  localparam logic [2:0] OP_SHL  = 3'd1;
  localparam logic [2:0] OP_ROR  = 3'd2;
  localparam logic [2:0] OP_ROL  = 3'd3;
  localparam logic [2:0] OP_ASR  = 3'd4;
  localparam logic [2:0] OP_LOAD = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Codes above LOAD complete immediately without touching q
  function automatic logic is_reserved(input logic [2:0] op);
    return op > OP_LOAD;
  endfunction

endpackage

// File: rtl/universal_shift_step.sv
// rtl/universal_shift_step.sv - next register value for one single-bit step
module universal_shift_step
  import universal_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       op,
  input  logic             sin_msb,
  input  logic             sin_lsb,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (op)
      OP_SHR:  q_next = {sin_msb, q[WIDTH-1:1]};
      OP_SHL:  q_next = {q[WIDTH-2:0], sin_lsb};
      OP_ROR:  q_next = {q[0], q[WIDTH-1:1]};
      OP_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      OP_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - multi-step universal shift register with start/busy/done handshake
module universal_shift_reg
  import universal_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] cnt,
  input  logic [WIDTH-1:0] d_load,
  input  logic             sin_msb,
  input  logic             sin_lsb,
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             busy,
  output logic             done
);

  state_t           state, state_n;
  logic [2:0]       op_r, op_n;
  logic [CNT_W-1:0] rem, rem_n;
  logic [WIDTH-1:0] q_n, q_step;
  logic             done_n;

  universal_shift_step #(.WIDTH(WIDTH)) u_step (
    .q       (q),
    .op      (op_r),
    .sin_msb (sin_msb),
    .sin_lsb (sin_lsb),
    .q_next  (q_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      op_r  <= OP_SHR;
      rem   <= '0;
      q     <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      op_r  <= op_n;
      rem   <= rem_n;
      q     <= q_n;
      done  <= done_n;
    end
  end

  // done defaults low every cycle, so a stall can never stretch it
  always_comb begin
    state_n = state;
    op_n    = op_r;
    rem_n   = rem;
    q_n     = q;
    done_n  = 1'b0;
    if (en) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (op == OP_LOAD) begin
              q_n    = d_load;
              done_n = 1'b1;
            end else if (is_reserved(op) || cnt == '0) begin
              done_n = 1'b1;
            end else begin
              op_n    = op;
              rem_n   = cnt;
              state_n = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          q_n   = q_step;
          rem_n = rem - CNT_W'(1);
          if (rem == CNT_W'(1)) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign busy     = (state == ST_RUN);
  assign sout_msb = q[WIDTH-1];
  assign sout_lsb = q[0];

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb/tb_universal_shift_reg.sv - scoreboard bench for universal_shift_reg
module tb_universal_shift_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             start = 1'b0;
  logic [2:0]       op = 3'd0;
  logic [CNT_W-1:0] cnt = '0;
  logic [WIDTH-1:0] d_load = '0;
  logic             sin_msb = 1'b0;
  logic             sin_lsb = 1'b0;
  logic [WIDTH-1:0] q;
  logic             sout_msb, sout_lsb, busy, done;

  typedef struct {
    logic [WIDTH-1:0] q;
    int               busy_cycles;
    string            name;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;
  int   busy_run = 0;

  universal_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .op(op), .cnt(cnt),
    .d_load(d_load), .sin_msb(sin_msb), .sin_lsb(sin_lsb), .q(q),
    .sout_msb(sout_msb), .sout_lsb(sout_lsb), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse retires one scoreboard entry
  always @(negedge clk) begin
    if (rst) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, "_q"}, 32'(q), 32'(e.q));
          chk({e.name, "_busy_cycles"}, 32'(busy_run), 32'(e.busy_cycles));
          chk({e.name, "_sout_msb"}, 32'(sout_msb), 32'(e.q[WIDTH-1]));
          chk({e.name, "_sout_lsb"}, 32'(sout_lsb), 32'(e.q[0]));
        end
        busy_run = 0;
      end
    end
  end

  // Drives a one-cycle start; when expect_done is set the result is queued
  task automatic cmd(input logic [2:0] o, input int n, input logic [WIDTH-1:0] d,
                     input bit expect_done, input logic [WIDTH-1:0] exp_q,
                     input int exp_busy, input string name);
    exp_t e;
    op = o; cnt = CNT_W'(n); d_load = d; start = 1'b1;
    if (expect_done) begin
      e.q = exp_q; e.busy_cycles = exp_busy; e.name = name;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
    op = 3'($urandom_range(0, 7)); cnt = CNT_W'($urandom); d_load = WIDTH'($urandom);
  endtask

  task automatic wait_done(input string name);
    int i;
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) break;
    end
    if (i == 40) chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    // Reset with random inputs, including start requests
    for (int i = 0; i < 2; i++) begin
      en = 1'b1; start = 1'($urandom); op = 3'($urandom); cnt = CNT_W'($urandom);
      d_load = WIDTH'($urandom); sin_msb = 1'($urandom); sin_lsb = 1'($urandom);
      @(negedge clk);
      chk("reset_q", 32'(q), 32'h00);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_q", 32'(q), 32'h00);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);

    // LOAD then SHL by 3 filling with ones
    sin_lsb = 1'b1;
    cmd(3'd5, 7, 8'hA5, 1, 8'hA5, 0, "load_a5");
    wait_done("load_a5");
    cmd(3'd1, 3, 8'h00, 1, 8'h2F, 3, "shl3");
    wait_done("shl3");

    // Rotates, including a count beyond WIDTH
    cmd(3'd5, 0, 8'h81, 1, 8'h81, 0, "load_81a");
    wait_done("load_81a");
    cmd(3'd2, 1, 8'h00, 1, 8'hC0, 1, "ror1");
    wait_done("ror1");
    cmd(3'd5, 0, 8'h81, 1, 8'h81, 0, "load_81b");
    wait_done("load_81b");
    cmd(3'd3, 9, 8'h00, 1, 8'h03, 9, "rol9");
    wait_done("rol9");

    // ASR, zero count and reserved op
    cmd(3'd5, 0, 8'h90, 1, 8'h90, 0, "load_90");
    wait_done("load_90");
    cmd(3'd4, 2, 8'h00, 1, 8'hE4, 2, "asr2");
    wait_done("asr2");
    cmd(3'd1, 0, 8'h00, 1, 8'hE4, 0, "cnt0");
    wait_done("cnt0");
    cmd(3'd6, 5, 8'h00, 1, 8'hE4, 0, "reserved");
    wait_done("reserved");

    // SHR with a 2-cycle stall and an ignored LOAD while busy
    sin_msb = 1'b0;
    cmd(3'd5, 0, 8'hF0, 1, 8'hF0, 0, "load_f0");
    wait_done("load_f0");
    cmd(3'd0, 4, 8'h00, 1, 8'h0F, 6, "shr4_stall");
    repeat (2) @(posedge clk);
    #1 en = 1'b0; start = 1'b1; op = 3'd5; d_load = 8'hFF;
    @(posedge clk); #1;
    chk("stall_hold_q", 32'(q), 32'h3C);
    chk("stall_hold_busy", 32'(busy), 32'd1);
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("shr4_stall");

    // Reset aborts a running SHL with no done
    sin_lsb = 1'b0;
    cmd(3'd1, 8, 8'h00, 0, 8'h00, 0, "shl8_abort");
    repeat (3) @(posedge clk);
    #1 chk("abort_pre_q", 32'(q), 32'h78);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("abort_q", 32'(q), 32'h00);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    cmd(3'd5, 0, 8'h3C, 1, 8'h3C, 0, "load_3c");
    wait_done("load_3c");

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
